time_word_decoder: RTL and testbench

//  Reader for the packed BCD time word that the clock page builds for the digit display.

---
 rtl/time_word_decoder.sv | 181 ++++++++++++++++++
 tb/tb_time_word_decoder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/time_word_decoder.sv
// time_word_decoder
// Reads one packed BCD time word per handshake and decodes it, one digit per
// cycle, into binary hours/minutes/seconds and seconds-of-day. Any malformed
// field produces err=1 with all-zero result values.
//
// Handshake contract (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. in_ready is high only in IDLE. Once
// out_valid rises, it and every result output stay stable until the edge
// that sees out_ready=1.
module time_word_decoder #(
  parameter int CHECK_SEP = 1,
  parameter int MAX_HR    = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] time_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  hr,
  output logic [5:0]  min,
  output logic [5:0]  sec,
  output logic [16:0] sod,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DECODE  = 2'd1,
    S_COMBINE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_shadow;
  logic [2:0]  r_step;
  logic [7:0]  r_hr_acc;
  logic [7:0]  r_min_acc;
  logic [7:0]  r_sec_acc;
  logic        r_err_acc;

  logic        r_out_valid;
  logic [4:0]  r_hr;
  logic [5:0]  r_min;
  logic [5:0]  r_sec;
  logic [16:0] r_sod;
  logic        r_err;

  logic [3:0]  w_nib;
  logic [3:0]  w_limit;
  logic [7:0]  w_x10;
  logic [7:0]  w_add;
  logic        w_digit_bad;
  logic        w_sep_bad;
  logic        w_err_final;
  logic [16:0] w_sod;

  // State register; reset aborts any decode in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic for IDLE -> DECODE(6) -> COMBINE -> DONE -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (in_valid) w_next = S_DECODE;
      S_DECODE:  if (r_step == 3'd5) w_next = S_COMBINE;
      S_COMBINE: w_next = S_DONE;
      S_DONE:    if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Digit selection and per-digit checks for the current decode step.
  // Even steps are tens digits, odd steps are units digits.
  always_comb begin
    w_nib   = 4'd0;
    w_limit = 4'd9;
    case (r_step)
      3'd0:    begin w_nib = r_shadow[31:28]; w_limit = 4'd2; end
      3'd1:    begin w_nib = r_shadow[27:24]; w_limit = 4'd9; end
      3'd2:    begin w_nib = r_shadow[19:16]; w_limit = 4'd5; end
      3'd3:    begin w_nib = r_shadow[15:12]; w_limit = 4'd9; end
      3'd4:    begin w_nib = r_shadow[7:4];   w_limit = 4'd5; end
      default: begin w_nib = r_shadow[3:0];   w_limit = 4'd9; end
    endcase
    w_x10       = ({4'd0, w_nib} << 3) + ({4'd0, w_nib} << 1);
    w_add       = r_step[0] ? {4'd0, w_nib} : w_x10;
    w_digit_bad = (w_nib > w_limit);
    w_sep_bad   = (CHECK_SEP != 0) && (r_step == 3'd0) &&
                  ((r_shadow[23:20] != 4'hF) || (r_shadow[11:8] != 4'hF));
  end

  // Final range check and seconds-of-day from the accumulated fields.
  always_comb begin
    w_err_final = r_err_acc || (r_hr_acc > 8'(MAX_HR));
    w_sod       = ({9'd0, r_hr_acc} * 17'd3600) + ({9'd0, r_min_acc} * 17'd60) +
                  {9'd0, r_sec_acc};
  end

  // Shadow capture and digit accumulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow  <= 32'd0;
      r_step    <= 3'd0;
      r_hr_acc  <= 8'd0;
      r_min_acc <= 8'd0;
      r_sec_acc <= 8'd0;
      r_err_acc <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shadow  <= time_data;
            r_step    <= 3'd0;
            r_hr_acc  <= 8'd0;
            r_min_acc <= 8'd0;
            r_sec_acc <= 8'd0;
            r_err_acc <= 1'b0;
          end
        end
        S_DECODE: begin
          r_step <= r_step + 3'd1;
          case (r_step[2:1])
            2'd0:    r_hr_acc  <= r_hr_acc + w_add;
            2'd1:    r_min_acc <= r_min_acc + w_add;
            default: r_sec_acc <= r_sec_acc + w_add;
          endcase
          if (w_digit_bad || w_sep_bad) r_err_acc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded only in COMBINE, out_valid dropped by the result handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_hr        <= 5'd0;
      r_min       <= 6'd0;
      r_sec       <= 6'd0;
      r_sod       <= 17'd0;
      r_err       <= 1'b0;
    end else begin
      if (r_state == S_COMBINE) begin
        r_out_valid <= 1'b1;
        r_err       <= w_err_final;
        if (w_err_final) begin
          r_hr  <= 5'd0;
          r_min <= 6'd0;
          r_sec <= 6'd0;
          r_sod <= 17'd0;
        end else begin
          r_hr  <= r_hr_acc[4:0];
          r_min <= r_min_acc[5:0];
          r_sec <= r_sec_acc[5:0];
          r_sod <= w_sod;
        end
      end else if ((r_state == S_DONE) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign hr        = r_hr;
  assign min       = r_min;
  assign sec       = r_sec;
  assign sod       = r_sod;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_time_word_decoder.sv
// Directed bench for time_word_decoder. Two instances share all inputs: one
// with separator checking, one without, so both run in lockstep.
module tb_time_word_decoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] time_data;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_err;
  logic [4:0]  a_hr;
  logic [5:0]  a_min, a_sec;
  logic [16:0] a_sod;
  logic [1:0]  a_state;

  logic        b_in_ready, b_out_valid, b_err;
  logic [4:0]  b_hr;
  logic [5:0]  b_min, b_sec;
  logic [16:0] b_sod;
  logic [1:0]  b_state;

  int n_checks = 0;
  int n_errors = 0;

  time_word_decoder #(.CHECK_SEP(1), .MAX_HR(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .time_data(time_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .hr(a_hr), .min(a_min), .sec(a_sec), .sod(a_sod), .err(a_err),
    .dbg_state(a_state)
  );

  time_word_decoder #(.CHECK_SEP(0), .MAX_HR(23)) dut_nosep (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .time_data(time_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .hr(b_hr), .min(b_min), .sec(b_sec), .sod(b_sod), .err(b_err),
    .dbg_state(b_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Wait for in_ready, present one word for a single accept edge.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    while (!a_in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val("ready_wait", {31'd0, a_in_ready}, 32'd1);
    time_data = w;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    time_data = $urandom;
  endtask

  // Count cycles from the accept edge to out_valid.
  task automatic wait_result();
    int n;
    n = 0;
    while (!a_out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_val("latency", n, 32'd7);
  endtask

  task automatic check_a(input string tag, input logic [4:0] e_hr, input logic [5:0] e_min,
                         input logic [5:0] e_sec, input logic [16:0] e_sod, input logic e_err);
    check_val({tag, "_hr"},  {27'd0, a_hr},  {27'd0, e_hr});
    check_val({tag, "_min"}, {26'd0, a_min}, {26'd0, e_min});
    check_val({tag, "_sec"}, {26'd0, a_sec}, {26'd0, e_sec});
    check_val({tag, "_sod"}, {15'd0, a_sod}, {15'd0, e_sod});
    check_val({tag, "_err"}, {31'd0, a_err}, {31'd0, e_err});
  endtask

  // Result handshake, then confirm the block is back in IDLE.
  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_val("ov_cleared", {31'd0, a_out_valid}, 32'd0);
    check_val("ready_back", {31'd0, a_in_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    time_data = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check_val("rst_in_ready",  {31'd0, a_in_ready},  32'd1);
    check_val("rst_state",     {30'd0, a_state},     32'd0);
    check_a("rst", 5'd0, 6'd0, 6'd0, 17'd0, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Largest legal time
    send_word(32'h23F59F59);
    wait_result();
    check_a("max", 5'd23, 6'd59, 6'd59, 17'd86399, 1'b0);
    take_result();
    check_val("retained_hr", {27'd0, a_hr}, 32'd23);

    // Midnight and a mid-day time
    send_word(32'h00F00F00);
    wait_result();
    check_a("zero", 5'd0, 6'd0, 6'd0, 17'd0, 1'b0);
    take_result();
    send_word(32'h12F34F56);
    wait_result();
    check_a("mid", 5'd12, 6'd34, 6'd56, 17'd45296, 1'b0);
    take_result();

    // Malformed fields
    send_word(32'h24F00F00);
    wait_result();
    check_a("hr24", 5'd0, 6'd0, 6'd0, 17'd0, 1'b1);
    take_result();
    send_word(32'h12F60F00);
    wait_result();
    check_a("min60", 5'd0, 6'd0, 6'd0, 17'd0, 1'b1);
    take_result();
    send_word(32'h12F00F0A);
    wait_result();
    check_a("units10", 5'd0, 6'd0, 6'd0, 17'd0, 1'b1);
    take_result();

    // Bad separators: rejected with checking, decoded by fields without it
    send_word(32'h12341234);
    wait_result();
    check_a("sep_on", 5'd0, 6'd0, 6'd0, 17'd0, 1'b1);
    check_val("sep_off_valid", {31'd0, b_out_valid}, 32'd1);
    check_val("sep_off_hr",  {27'd0, b_hr},  32'd12);
    check_val("sep_off_min", {26'd0, b_min}, 32'd41);
    check_val("sep_off_sec", {26'd0, b_sec}, 32'd34);
    check_val("sep_off_sod", {15'd0, b_sod}, 32'd45694);
    check_val("sep_off_err", {31'd0, b_err}, 32'd0);
    take_result();

    // Stall in DONE while a new word is offered
    send_word(32'h09F15F30);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      time_data = 32'h01F01F01;
      @(posedge clk); #1;
      check_val("stall_valid", {31'd0, a_out_valid}, 32'd1);
      check_val("stall_ready", {31'd0, a_in_ready},  32'd0);
      check_val("stall_sod",   {15'd0, a_sod},       32'd33330);
    end
    in_valid = 1'b0;
    check_a("stall", 5'd9, 6'd15, 6'd30, 17'd33330, 1'b0);
    take_result();
    repeat (9) @(posedge clk);
    #1;
    check_val("no_ghost_word", {31'd0, a_out_valid}, 32'd0);
    check_val("still_idle",    {31'd0, a_in_ready},  32'd1);

    // Reset in the third DECODE cycle
    send_word(32'h12F34F56);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("pre_rst_state", {30'd0, a_state}, 32'd1);
    rst = 1'b0;
    #1;
    check_val("abort_valid", {31'd0, a_out_valid}, 32'd0);
    check_val("abort_ready", {31'd0, a_in_ready},  32'd1);
    check_a("abort", 5'd0, 6'd0, 6'd0, 17'd0, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    send_word(32'h07F08F09);
    wait_result();
    check_a("after_rst", 5'd7, 6'd8, 6'd9, 17'd25689, 1'b0);
    take_result();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
